// File: rtl/oc8051_div_ctrl.sv
// oc8051_div_ctrl: round-robin sequencer sharing one 4-cycle divider between two requesters
module oc8051_div_ctrl #(
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack1,
  output logic       done,
  output logic       res_id,
  output logic [7:0] res_quot,
  output logic [7:0] res_rem,
  output logic       res_ov,
  output logic       busy,
  output logic       div_en,
  output logic [7:0] div_src1,
  output logic [7:0] div_src2,
  input  logic [7:0] div_des1,
  input  logic [7:0] div_des2,
  input  logic       div_ov
);
  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;
  state_t state;
  logic [1:0] cnt;
  logic last_grant, gnt;
  logic [7:0] sel_a, sel_b;
  // on a tie the requester not served last wins
  assign gnt = (req0 && req1) ? ~last_grant : req1;
  assign sel_a = gnt ? a1 : a0;
  assign sel_b = gnt ? b1 : b0;
  assign div_en = state == RUN;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      res_id <= 1'b0;
      res_quot <= 8'h00;
      res_rem <= 8'h00;
      res_ov <= 1'b0;
      last_grant <= 1'b1;
      div_src1 <= 8'h00;
      div_src2 <= 8'h00;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          ack0 <= ~gnt;
          ack1 <= gnt;
          res_id <= gnt;
          last_grant <= gnt;
          div_src1 <= sel_a;
          div_src2 <= sel_b;
          busy <= 1'b1;
          cnt <= 2'd0;
          state <= (ZERO_FAST && sel_b == 8'h00) ? ZERO : RUN;
        end
        RUN: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            res_rem <= div_des1;
            res_quot <= div_des2;
            res_ov <= div_ov;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        ZERO: begin
          res_quot <= 8'hFF;
          res_rem <= div_src1;
          res_ov <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oc8051_div_ctrl.sv
// tb_oc8051_div_ctrl: scoreboard bench for the shared divider sequencer
module tb_oc8051_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic ack0, ack1, done, res_id, res_ov, busy, div_en, div_ov;
  logic [7:0] res_quot, res_rem, div_src1, div_src2, div_des1, div_des2;
  logic z_req = 0;
  logic [7:0] z_a = 0, z_b = 0;
  logic z_ack0, z_ack1, z_done, z_id, z_ov, z_busy, z_en, z_dov;
  logic [7:0] z_quot, z_rem, z_s1, z_s2, z_d1, z_d2;
  logic [1:0] dc, z_dc;
  int compared = 0, mismatched = 0, cyc = 0, ack_cyc = 0, done_cyc = 0, en_cnt = 0;

  typedef struct {
    logic id;
    logic [7:0] quot, rem;
    logic ov;
    int en, lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  oc8051_div_ctrl #(.ZERO_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .done(done), .res_id(res_id),
    .res_quot(res_quot), .res_rem(res_rem), .res_ov(res_ov), .busy(busy),
    .div_en(div_en), .div_src1(div_src1), .div_src2(div_src2),
    .div_des1(div_des1), .div_des2(div_des2), .div_ov(div_ov));

  oc8051_div_ctrl #(.ZERO_FAST(1'b0)) dut_slow (
    .clk(clk), .rst(rst), .req0(z_req), .a0(z_a), .b0(z_b), .ack0(z_ack0),
    .req1(1'b0), .a1(8'h00), .b1(8'h00), .ack1(z_ack1), .done(z_done), .res_id(z_id),
    .res_quot(z_quot), .res_rem(z_rem), .res_ov(z_ov), .busy(z_busy),
    .div_en(z_en), .div_src1(z_s1), .div_src2(z_s2),
    .div_des1(z_d1), .div_des2(z_d2), .div_ov(z_dov));

  // divider: result only valid in the 4th enabled cycle; {ov, rem, quot}
  function automatic logic [16:0] dmodel(input logic [7:0] s1, input logic [7:0] s2, input logic [1:0] c);
    if (c != 2'd3) return {1'b0, 8'hEE, 8'hDD};
    if (s2 == 8'h00) return {1'b1, s1, 8'hFF};
    return {1'b0, s1 % s2, s1 / s2};
  endfunction
  assign {div_ov, div_des1, div_des2} = dmodel(div_src1, div_src2, dc);
  assign {z_dov, z_d1, z_d2} = dmodel(z_s1, z_s2, z_dc);
  always @(posedge clk or negedge rst)
    if (!rst) begin dc <= 2'd0; z_dc <= 2'd0; end
    else begin
      if (div_en) dc <= dc + 2'd1;
      if (z_en) z_dc <= z_dc + 2'd1;
    end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] q, input logic [7:0] r, input logic ov, input bit zero);
    exp_t e;
    e.id = id; e.quot = q; e.rem = r; e.ov = ov;
    e.en = zero ? 0 : 4;
    e.lat = zero ? 1 : 4;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input logic id);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(id ? ack1 : ack0) && k < 50);
    if (!(id ? ack1 : ack0)) begin
      compared++; mismatched++;
      $display("FAIL ack%0d_timeout: got none expected ack within 50 cycles", id);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while ((busy || sb.size() != 0) && k < 100);
    if (busy || sb.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // monitor: pops the scoreboard on every done
  always @(negedge clk) begin
    if (!rst) en_cnt = 0;
    else begin
      if (div_en) en_cnt++;
      if (ack0 && ack1) begin
        compared++; mismatched++;
        $display("FAIL ack_both: got ack0=1 ack1=1 expected one-hot");
      end
      if (ack0 || ack1) begin
        ack_cyc = cyc;
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL ack_unexpected: got ack expected none");
        end else chk("ack_id", {15'd0, ack1}, {15'd0, sb[0].id});
      end
      if (done) begin
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL done_unexpected: got done expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_quot", {8'd0, res_quot}, {8'd0, e.quot});
          chk("res_rem", {8'd0, res_rem}, {8'd0, e.rem});
          chk("res_ov", {15'd0, res_ov}, {15'd0, e.ov});
          chk("res_id", {15'd0, res_id}, {15'd0, e.id});
          chk("div_en_cycles", 16'(en_cnt), 16'(e.en));
          chk("latency", 16'(cyc - ack_cyc), 16'(e.lat));
        end
        en_cnt = 0;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, early, zen;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack0", {15'd0, ack0}, 0);
    chk("rst_ack1", {15'd0, ack1}, 0);
    chk("rst_done", {15'd0, done}, 0);
    chk("rst_busy", {15'd0, busy}, 0);
    chk("rst_div_en", {15'd0, div_en}, 0);
    chk("rst_quot", {8'd0, res_quot}, 0);
    chk("rst_rem", {8'd0, res_rem}, 0);
    chk("rst_ov_id", {14'd0, res_ov, res_id}, 0);
    chk("rst_src", {div_src1, div_src2}, 0);
    rst = 1'b1;
    @(negedge clk);
    // single op
    push(0, 8'd14, 8'd2, 0, 0);
    req0 = 1; a0 = 100; b0 = 7;
    wait_ack(0); req0 = 0;
    wait_idle();
    // back-to-back from requester 1
    push(1, 8'd66, 8'd2, 0, 0);
    push(1, 8'd255, 8'd0, 0, 0);
    req1 = 1; a1 = 200; b1 = 3;
    wait_ack(1); a1 = 255; b1 = 1;
    wait_ack(1);
    chk("b2b_gap", 16'(cyc - done_cyc), 16'd1);
    req1 = 0;
    wait_idle();
    // tie twice: last grant was 1, so 0 then 1 each time
    for (int t = 0; t < 2; t++) begin
      push(0, 8'd0, 8'd5, 0, 0);
      push(1, 8'd1, 8'd4, 0, 0);
      req0 = 1; a0 = 5; b0 = 9; req1 = 1; a1 = 9; b1 = 5;
      wait_ack(0); req0 = 0;
      wait_ack(1); req1 = 0;
      wait_idle();
    end
    // tie after a lone req0 grant favours requester 1
    push(0, 8'd14, 8'd2, 0, 0);
    req0 = 1; a0 = 100; b0 = 7;
    wait_ack(0); req0 = 0;
    wait_idle();
    push(1, 8'd1, 8'd4, 0, 0);
    push(0, 8'd0, 8'd5, 0, 0);
    req0 = 1; a0 = 5; b0 = 9; req1 = 1; a1 = 9; b1 = 5;
    wait_ack(1); req1 = 0;
    wait_ack(0); req0 = 0;
    wait_idle();
    // divide by zero, fast path
    push(0, 8'hFF, 8'd42, 1, 1);
    req0 = 1; a0 = 42; b0 = 0;
    wait_ack(0); req0 = 0;
    wait_idle();
    // reset at cnt==2 aborts the op
    push(0, 8'd14, 8'd2, 0, 0);
    req0 = 1; a0 = 100; b0 = 7;
    wait_ack(0); req0 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_outputs", {12'd0, ack0, ack1, done, busy}, 0);
    chk("abort_div_en", {15'd0, div_en}, 0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push(0, 8'd14, 8'd2, 0, 0);
    req0 = 1; a0 = 100; b0 = 7;
    wait_ack(0); req0 = 0;
    wait_idle();
    // late request while busy
    push(0, 8'd14, 8'd2, 0, 0);
    req0 = 1; a0 = 100; b0 = 7;
    wait_ack(0); req0 = 0;
    push(1, 8'd1, 8'd4, 0, 0);
    req1 = 1; a1 = 9; b1 = 5;
    early = 0; k = 0;
    do begin @(negedge clk); k++; if (ack1) early++; end while (busy && k < 20);
    chk("late_no_ack1", 16'(early), 0);
    wait_ack(1); req1 = 0;
    wait_idle();
    chk("sb_empty", 16'(sb.size()), 0);
    // divide by zero, full sequence
    z_req = 1; z_a = 42; z_b = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!z_ack0 && k < 50);
    chk("slow_ack0", {15'd0, z_ack0}, 1);
    z_req = 0; zen = 0; k = 0;
    while (!z_done && k < 20) begin
      if (z_en) zen++;
      @(negedge clk); k++;
    end
    chk("slow_latency", 16'(k), 16'd4);
    chk("slow_div_en_cycles", 16'(zen), 16'd4);
    chk("slow_ov", {15'd0, z_ov}, 1);
    chk("slow_quot_rem", {z_quot, z_rem}, {8'hFF, 8'd42});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
